gshare_btb_ongorucu: RTL and testbench

Parametrised gshare branch predictor with a direct-mapped branch target buffer (BTB) for the fetch stage. The fetch PC is hashed with a speculative global history register (GHR) to index a table of 2-bit saturating counters. A taken prediction supplies a registered target from the BTB one cycle later. Execute-stage resolutions train both tables, and mispredictions repair the GHR from a per-branch history snapshot that travels down the pipeline.

---
 rtl/gshare_btb_ongorucu.sv | 132 +++++++++++++
 tb/tb_gshare_btb_ongorucu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gshare_btb_ongorucu.sv
// Gshare direction predictor with a direct-mapped BTB for the fetch stage.
// One registered prediction per cycle; execute-stage resolutions train and repair.
module gshare_btb_ongorucu #(
  parameter int unsigned GHR_W = 8,
  parameter int unsigned PHT_W = 8,
  parameter int unsigned BTB_W = 4,
  parameter int unsigned TAG_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      getir_ps_i,
  input  logic             getir_gecerli_i,
  output logic             sonuc_gecerli_o,
  output logic             sonuc_dallan_o,
  output logic [31:0]      sonuc_dallan_ps_o,
  output logic [GHR_W-1:0] sonuc_ghr_o,
  input  logic             yurut_gecerli_i,
  input  logic [31:0]      yurut_ps_i,
  input  logic [GHR_W-1:0] yurut_ghr_i,
  input  logic             yurut_atladi_i,
  input  logic [31:0]      yurut_hedef_i,
  input  logic             yurut_yanlis_tahmin_i
);

  localparam int unsigned PHT_N   = 1 << PHT_W;
  localparam int unsigned BTB_N   = 1 << BTB_W;
  localparam int unsigned TAG_LSB = BTB_W + 2;
  localparam int unsigned TAG_MSB = BTB_W + TAG_W + 1;

  localparam logic [1:0] SAYAC_GT = 2'd0;
  localparam logic [1:0] SAYAC_ZT = 2'd1;
  localparam logic [1:0] SAYAC_GA = 2'd3;

  logic [1:0]       pht_q [PHT_N];
  logic [BTB_N-1:0] btb_gecerli_q;
  logic [TAG_W-1:0] btb_etiket_q [BTB_N];
  logic [31:0]      btb_hedef_q [BTB_N];
  logic [GHR_W-1:0] ghr_q;

  logic [PHT_W-1:0] pidx_c;
  logic [BTB_W-1:0] bidx_c;
  logic [TAG_W-1:0] etiket_c;
  logic             btb_isabet_c;
  logic             dallan_c;
  logic [31:0]      hedef_c;

  logic [PHT_W-1:0] uidx_c;
  logic [BTB_W-1:0] ubidx_c;
  logic [TAG_W-1:0] uetiket_c;
  logic [1:0]       sayac_c;
  logic [1:0]       sayac_yeni_c;
  logic             onarim_c;
  logic             yurut_ps_unused_c;

  // Fetch-side lookup on current (pre-update) table contents
  always_comb begin
    pidx_c       = getir_ps_i[PHT_W+1:2] ^ PHT_W'(ghr_q);
    bidx_c       = getir_ps_i[BTB_W+1:2];
    etiket_c     = getir_ps_i[TAG_MSB:TAG_LSB];
    btb_isabet_c = btb_gecerli_q[bidx_c] && (btb_etiket_q[bidx_c] == etiket_c);
    dallan_c     = pht_q[pidx_c][1] && btb_isabet_c;
    hedef_c      = dallan_c ? btb_hedef_q[bidx_c] : (getir_ps_i + 32'd4);
  end

  // Execute-side training index and saturating counter step
  always_comb begin
    uidx_c       = yurut_ps_i[PHT_W+1:2] ^ PHT_W'(yurut_ghr_i);
    ubidx_c      = yurut_ps_i[BTB_W+1:2];
    uetiket_c    = yurut_ps_i[TAG_MSB:TAG_LSB];
    sayac_c      = pht_q[uidx_c];
    sayac_yeni_c = sayac_c;
    if (yurut_atladi_i) begin
      if (sayac_c != SAYAC_GA) sayac_yeni_c = sayac_c + 2'd1;
    end else begin
      if (sayac_c != SAYAC_GT) sayac_yeni_c = sayac_c - 2'd1;
    end
    onarim_c          = yurut_gecerli_i && yurut_yanlis_tahmin_i;
    yurut_ps_unused_c = ^yurut_ps_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht_q[i] <= SAYAC_ZT;
    end else if (yurut_gecerli_i) begin
      pht_q[uidx_c] <= sayac_yeni_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btb_gecerli_q <= '0;
    end else if (yurut_gecerli_i && yurut_atladi_i) begin
      btb_gecerli_q[ubidx_c] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by the valid bit, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (yurut_gecerli_i && yurut_atladi_i) begin
      btb_etiket_q[ubidx_c] <= uetiket_c;
      btb_hedef_q[ubidx_c]  <= yurut_hedef_i;
    end
  end

  // Repair takes priority; a fetch in the same cycle never reaches the history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q <= '0;
    end else if (onarim_c) begin
      ghr_q <= GHR_W'({yurut_ghr_i, yurut_atladi_i});
    end else if (getir_gecerli_i) begin
      ghr_q <= GHR_W'({ghr_q, dallan_c});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sonuc_gecerli_o   <= 1'b0;
      sonuc_dallan_o    <= 1'b0;
      sonuc_dallan_ps_o <= '0;
      sonuc_ghr_o       <= '0;
    end else begin
      sonuc_gecerli_o <= getir_gecerli_i;
      if (getir_gecerli_i) begin
        sonuc_dallan_o    <= dallan_c;
        sonuc_dallan_ps_o <= hedef_c;
        sonuc_ghr_o       <= ghr_q;
      end
    end
  end

endmodule

// File: tb/tb_gshare_btb_ongorucu.sv
// Directed self-checking bench for gshare_btb_ongorucu with default parameters.
module tb_gshare_btb_ongorucu;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] getir_ps_i = '0;
  logic        getir_gecerli_i = 1'b0;
  logic        sonuc_gecerli_o;
  logic        sonuc_dallan_o;
  logic [31:0] sonuc_dallan_ps_o;
  logic [7:0]  sonuc_ghr_o;
  logic        yurut_gecerli_i = 1'b0;
  logic [31:0] yurut_ps_i = '0;
  logic [7:0]  yurut_ghr_i = '0;
  logic        yurut_atladi_i = 1'b0;
  logic [31:0] yurut_hedef_i = '0;
  logic        yurut_yanlis_tahmin_i = 1'b0;

  int total = 0;
  int bad = 0;

  gshare_btb_ongorucu dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .getir_ps_i            (getir_ps_i),
    .getir_gecerli_i       (getir_gecerli_i),
    .sonuc_gecerli_o       (sonuc_gecerli_o),
    .sonuc_dallan_o        (sonuc_dallan_o),
    .sonuc_dallan_ps_o     (sonuc_dallan_ps_o),
    .sonuc_ghr_o           (sonuc_ghr_o),
    .yurut_gecerli_i       (yurut_gecerli_i),
    .yurut_ps_i            (yurut_ps_i),
    .yurut_ghr_i           (yurut_ghr_i),
    .yurut_atladi_i        (yurut_atladi_i),
    .yurut_hedef_i         (yurut_hedef_i),
    .yurut_yanlis_tahmin_i (yurut_yanlis_tahmin_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [7:0] ghr, input logic taken,
                         input logic [31:0] tgt, input logic mis);
    yurut_gecerli_i       = 1'b1;
    yurut_ps_i            = pc;
    yurut_ghr_i           = ghr;
    yurut_atladi_i        = taken;
    yurut_hedef_i         = tgt;
    yurut_yanlis_tahmin_i = mis;
    tick();
    yurut_gecerli_i       = 1'b0;
    yurut_yanlis_tahmin_i = 1'b0;
  endtask

  // Repair through a PC whose PHT slot (0xFF ^ snapshot) is not used by the tests
  task automatic force_ghr(input logic [7:0] val);
    resolve(32'hFFC, {1'b0, val[7:1]}, val[0], 32'h0, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] pc);
    getir_ps_i      = pc;
    getir_gecerli_i = 1'b1;
    tick();
    getir_gecerli_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (sonuc_gecerli_o !== 1'b0) begin bad++; $display("FAIL rst_gecerli got=%0b exp=0", sonuc_gecerli_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h0) begin bad++; $display("FAIL rst_ps got=%h exp=0", sonuc_dallan_ps_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    fetch(32'h100);
    total++; if (sonuc_gecerli_o !== 1'b1) begin bad++; $display("FAIL t1_gecerli got=%0b exp=1", sonuc_gecerli_o); end
    total++; if (sonuc_dallan_o !== 1'b0) begin bad++; $display("FAIL t1_dallan got=%0b exp=0", sonuc_dallan_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h104) begin bad++; $display("FAIL t1_ps got=%h exp=104", sonuc_dallan_ps_o); end
    total++; if (sonuc_ghr_o !== 8'h00) begin bad++; $display("FAIL t1_ghr got=%h exp=00", sonuc_ghr_o); end
    tick();
    total++; if (sonuc_gecerli_o !== 1'b0) begin bad++; $display("FAIL t1_gecerli_drop got=%0b exp=0", sonuc_gecerli_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h104) begin bad++; $display("FAIL t1_hold_ps got=%h exp=104", sonuc_dallan_ps_o); end
  endtask

  task automatic test_train_taken();
    resolve(32'h200, 8'h00, 1'b1, 32'h80, 1'b0);
    resolve(32'h200, 8'h00, 1'b1, 32'h80, 1'b0);
    force_ghr(8'h00);
    fetch(32'h200);
    total++; if (sonuc_dallan_o !== 1'b1) begin bad++; $display("FAIL t2_dallan got=%0b exp=1", sonuc_dallan_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h80) begin bad++; $display("FAIL t2_ps got=%h exp=80", sonuc_dallan_ps_o); end
    // Taken prediction shifts a 1 into the history
    fetch(32'h100);
    total++; if (sonuc_ghr_o !== 8'h01) begin bad++; $display("FAIL t2_spec_ghr got=%h exp=01", sonuc_ghr_o); end
  endtask

  task automatic test_btb_alias();
    // GHR 0x10 maps 0x240 onto the GA counter at index 0x80; only the tag differs
    force_ghr(8'h10);
    fetch(32'h240);
    total++; if (sonuc_dallan_o !== 1'b0) begin bad++; $display("FAIL t3_dallan got=%0b exp=0", sonuc_dallan_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h244) begin bad++; $display("FAIL t3_ps got=%h exp=244", sonuc_dallan_ps_o); end
    total++; if (sonuc_ghr_o !== 8'h10) begin bad++; $display("FAIL t3_ghr got=%h exp=10", sonuc_ghr_o); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) resolve(32'h300, 8'h00, 1'b1, 32'h400, 1'b0);
    resolve(32'h300, 8'h00, 1'b0, 32'h0, 1'b0);
    force_ghr(8'h00);
    fetch(32'h300);
    total++; if (sonuc_dallan_o !== 1'b1) begin bad++; $display("FAIL t4_za_dallan got=%0b exp=1", sonuc_dallan_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h400) begin bad++; $display("FAIL t4_za_ps got=%h exp=400", sonuc_dallan_ps_o); end
    resolve(32'h300, 8'h00, 1'b0, 32'h0, 1'b0);
    force_ghr(8'h00);
    fetch(32'h300);
    total++; if (sonuc_dallan_o !== 1'b0) begin bad++; $display("FAIL t4_zt_dallan got=%0b exp=0", sonuc_dallan_o); end
    for (int i = 0; i < 6; i++) resolve(32'h304, 8'h00, 1'b0, 32'h0, 1'b0);
    resolve(32'h304, 8'h00, 1'b1, 32'h500, 1'b0);
    force_ghr(8'h00);
    fetch(32'h304);
    total++; if (sonuc_dallan_o !== 1'b0) begin bad++; $display("FAIL t4_gt_dallan got=%0b exp=0", sonuc_dallan_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h308) begin bad++; $display("FAIL t4_gt_ps got=%h exp=308", sonuc_dallan_ps_o); end
    resolve(32'h304, 8'h00, 1'b1, 32'h500, 1'b0);
    force_ghr(8'h00);
    fetch(32'h304);
    total++; if (sonuc_dallan_o !== 1'b1) begin bad++; $display("FAIL t4_gt2_dallan got=%0b exp=1", sonuc_dallan_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h500) begin bad++; $display("FAIL t4_gt2_ps got=%h exp=500", sonuc_dallan_ps_o); end
  endtask

  task automatic test_repair_fetch();
    force_ghr(8'h33);
    getir_ps_i            = 32'h100;
    getir_gecerli_i       = 1'b1;
    yurut_gecerli_i       = 1'b1;
    yurut_ps_i            = 32'hFFC;
    yurut_ghr_i           = 8'h5A;
    yurut_atladi_i        = 1'b1;
    yurut_hedef_i         = 32'h0;
    yurut_yanlis_tahmin_i = 1'b1;
    tick();
    yurut_gecerli_i       = 1'b0;
    yurut_yanlis_tahmin_i = 1'b0;
    total++; if (sonuc_gecerli_o !== 1'b1) begin bad++; $display("FAIL t5_gecerli got=%0b exp=1", sonuc_gecerli_o); end
    total++; if (sonuc_ghr_o !== 8'h33) begin bad++; $display("FAIL t5_snap got=%h exp=33", sonuc_ghr_o); end
    tick();
    total++; if (sonuc_ghr_o !== 8'hB5) begin bad++; $display("FAIL t5_repair got=%h exp=b5", sonuc_ghr_o); end
    getir_gecerli_i = 1'b0;
  endtask

  task automatic test_async_reset();
    resolve(32'h200, 8'h00, 1'b1, 32'h80, 1'b0);
    force_ghr(8'h00);
    getir_ps_i      = 32'h200;
    getir_gecerli_i = 1'b1;
    tick();
    getir_gecerli_i = 1'b0;
    total++; if (sonuc_dallan_o !== 1'b1) begin bad++; $display("FAIL t6_pre_dallan got=%0b exp=1", sonuc_dallan_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    total++; if (sonuc_gecerli_o !== 1'b0) begin bad++; $display("FAIL t6_gecerli got=%0b exp=0", sonuc_gecerli_o); end
    total++; if (sonuc_dallan_o !== 1'b0) begin bad++; $display("FAIL t6_dallan got=%0b exp=0", sonuc_dallan_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h0) begin bad++; $display("FAIL t6_ps got=%h exp=0", sonuc_dallan_ps_o); end
    total++; if (sonuc_ghr_o !== 8'h00) begin bad++; $display("FAIL t6_ghr got=%h exp=00", sonuc_ghr_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    fetch(32'h200);
    total++; if (sonuc_dallan_o !== 1'b0) begin bad++; $display("FAIL t6_post_dallan got=%0b exp=0", sonuc_dallan_o); end
    total++; if (sonuc_dallan_ps_o !== 32'h204) begin bad++; $display("FAIL t6_post_ps got=%h exp=204", sonuc_dallan_ps_o); end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_btb_alias();
    test_saturation();
    test_repair_fetch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
